// File: rtl/fb_arbiter.sv
// fb_arbiter -- shares one single-port synchronous framebuffer RAM between
// VGA scanout and a pixel writer.
//
// The slot flop toggles on every CLOCK_50 edge. Slot 0 belongs to scanout and
// slot 1 belongs to the writer. When scanout is blanked (vga_en low), slot 0
// is handed to the writer as well. Scanout data lands in vga_d two edges after
// its address is presented. It then holds until the next scanout result.
//
// Optional feature (macro FB_ARB_WQUEUE_EN): writes are posted into a
// WQ_DEPTH-entry FIFO and acked immediately. The FIFO head drains into the RAM
// once per granted slot. A read is only accepted once the FIFO is empty, so a
// read never overtakes an earlier write.
//
// Ports:
//   CLOCK_50   in   sole clock
//   reset      in   asynchronous active-low reset
//   vga_adr    in   scanout read address (used in scanout slots)
//   vga_en     in   scanout active; low donates scanout slots to the writer
//   vga_d      out  registered scanout pixel
//   wr_req     in   writer request (held until wr_ack)
//   wr_we      in   1 = write, 0 = read
//   wr_adr     in   writer address
//   wr_wdata   in   writer write data
//   wr_ack     out  request accepted (one-cycle pulse)
//   wr_rvalid  out  wr_rdata valid (one-cycle pulse)
//   wr_rdata   out  registered writer read data
//   mem_adr    out  RAM address
//   mem_we     out  RAM write enable
//   mem_wdata  out  RAM write data
//   mem_rdata  in   RAM read data, valid one cycle after mem_adr
module fb_arbiter #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 24,
    parameter int WQ_DEPTH = 4
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic [ADDR_W-1:0] vga_adr,
    input  logic              vga_en,
    output logic [DATA_W-1:0] vga_d,
    input  logic              wr_req,
    input  logic              wr_we,
    input  logic [ADDR_W-1:0] wr_adr,
    input  logic [DATA_W-1:0] wr_wdata,
    output logic              wr_ack,
    output logic              wr_rvalid,
    output logic [DATA_W-1:0] wr_rdata,
    output logic [ADDR_W-1:0] mem_adr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } wr_state_t;

    wr_state_t         state_reg, state_next;
    logic              slot_reg;
    logic              scan_pend_reg;
    logic [DATA_W-1:0] vga_d_reg;
    logic [DATA_W-1:0] wr_rdata_reg;
    logic              wr_rvalid_reg;

    logic              granted;
    logic              scan_slot;
    logic              issue_we;
    logic [ADDR_W-1:0] issue_adr;
    logic [DATA_W-1:0] issue_wdata;
    logic              ack;

    // The writer owns slot 1 always, and slot 0 whenever scanout is blanked.
    assign granted   = slot_reg | ~vga_en;
    assign scan_slot = ~slot_reg & vga_en;

`ifdef FB_ARB_WQUEUE_EN
    localparam int PTR_W = $clog2(WQ_DEPTH);

    logic [ADDR_W-1:0] wq_adr_mem  [WQ_DEPTH];
    logic [DATA_W-1:0] wq_data_mem [WQ_DEPTH];
    logic [PTR_W:0]    wq_wr_ptr_reg, wq_rd_ptr_reg;
    logic              wq_empty, wq_full, wq_push, wq_pop;

    // Extra pointer bit tells a full queue apart from an empty one.
    assign wq_empty = (wq_wr_ptr_reg == wq_rd_ptr_reg);
    assign wq_full  = (wq_wr_ptr_reg[PTR_W] != wq_rd_ptr_reg[PTR_W]) &&
                      (wq_wr_ptr_reg[PTR_W-1:0] == wq_rd_ptr_reg[PTR_W-1:0]);
    // Fullness comes from the registered pointers. A push at full is therefore
    // refused even when the head drains in the same cycle.
    assign wq_push  = reset & wr_req & wr_we & ~wq_full;

    always_comb begin
        state_next  = state_reg;
        issue_we    = 1'b0;
        issue_adr   = vga_adr;
        issue_wdata = '0;
        ack         = wq_push;
        wq_pop      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (granted && !wq_empty) begin
                    wq_pop      = 1'b1;
                    issue_we    = 1'b1;
                    issue_adr   = wq_adr_mem[wq_rd_ptr_reg[PTR_W-1:0]];
                    issue_wdata = wq_data_mem[wq_rd_ptr_reg[PTR_W-1:0]];
                end else if (granted && wr_req && !wr_we && wq_empty) begin
                    ack        = 1'b1;
                    issue_adr  = wr_adr;
                    state_next = RD_WAIT;
                end
            end
            RD_WAIT: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (wq_push) begin
            wq_adr_mem[wq_wr_ptr_reg[PTR_W-1:0]]  <= wr_adr;
            wq_data_mem[wq_wr_ptr_reg[PTR_W-1:0]] <= wr_wdata;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            wq_wr_ptr_reg <= '0;
            wq_rd_ptr_reg <= '0;
        end else begin
            if (wq_push) wq_wr_ptr_reg <= wq_wr_ptr_reg + 1'b1;
            if (wq_pop)  wq_rd_ptr_reg <= wq_rd_ptr_reg + 1'b1;
        end
    end
`else
    always_comb begin
        state_next  = state_reg;
        issue_we    = 1'b0;
        issue_adr   = vga_adr;
        issue_wdata = '0;
        ack         = 1'b0;
        case (state_reg)
            IDLE: begin
                if (granted && wr_req) begin
                    ack         = 1'b1;
                    issue_we    = wr_we;
                    issue_adr   = wr_adr;
                    issue_wdata = wr_wdata;
                    if (!wr_we) state_next = RD_WAIT;
                end
            end
            RD_WAIT: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end
`endif

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            slot_reg      <= 1'b0;
            state_reg     <= IDLE;
            scan_pend_reg <= 1'b0;
            vga_d_reg     <= '0;
            wr_rdata_reg  <= '0;
            wr_rvalid_reg <= 1'b0;
        end else begin
            slot_reg      <= ~slot_reg;
            state_reg     <= state_next;
            // The scanout address went out last cycle, so mem_rdata now holds its pixel.
            scan_pend_reg <= scan_slot;
            if (scan_pend_reg) vga_d_reg <= mem_rdata;
            // RD_WAIT is the cycle in which the writer's read data is on mem_rdata.
            // Registering it puts rvalid and rdata out together in the cycle after.
            wr_rvalid_reg <= (state_reg == RD_WAIT);
            if (state_reg == RD_WAIT) wr_rdata_reg <= mem_rdata;
        end
    end

    // The combinational outputs are forced to zero while reset is held.
    assign mem_adr   = reset ? issue_adr : '0;
    assign mem_we    = reset & issue_we;
    assign mem_wdata = reset ? issue_wdata : '0;
    assign wr_ack    = reset & ack;
    assign vga_d     = vga_d_reg;
    assign wr_rdata  = wr_rdata_reg;
    assign wr_rvalid = wr_rvalid_reg;

endmodule

// File: tb/tb_fb_arbiter.sv
module tb_fb_arbiter;
    localparam int AW = 16;
    localparam int DW = 24;

    logic          CLOCK_50 = 1'b0;
    logic          reset    = 1'b0;
    logic [AW-1:0] vga_adr  = '0;
    logic          vga_en   = 1'b0;
    logic [DW-1:0] vga_d;
    logic          wr_req   = 1'b0;
    logic          wr_we    = 1'b0;
    logic [AW-1:0] wr_adr   = '0;
    logic [DW-1:0] wr_wdata = '0;
    logic          wr_ack;
    logic          wr_rvalid;
    logic [DW-1:0] wr_rdata;
    logic [AW-1:0] mem_adr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] ram [0:65535];

    fb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WQ_DEPTH(4)) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .vga_adr  (vga_adr),
        .vga_en   (vga_en),
        .vga_d    (vga_d),
        .wr_req   (wr_req),
        .wr_we    (wr_we),
        .wr_adr   (wr_adr),
        .wr_wdata (wr_wdata),
        .wr_ack   (wr_ack),
        .wr_rvalid(wr_rvalid),
        .wr_rdata (wr_rdata),
        .mem_adr  (mem_adr),
        .mem_we   (mem_we),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // Single-port synchronous RAM model, read-before-write
    always @(posedge CLOCK_50) begin
        if (mem_we) ram[mem_adr] <= mem_wdata;
        mem_rdata <= ram[mem_adr];
    end

    task automatic tick;
        @(posedge CLOCK_50);
        #1;
    endtask

    // Leaves the bench 2 time units into the first slot-0 cycle after release.
    task automatic do_reset;
        reset = 1'b0;
        @(posedge CLOCK_50);
        @(posedge CLOCK_50);
        #1 reset = 1'b1;
        #1;
    endtask

    task automatic test_reset;
        vga_en = 1'b1; vga_adr = 16'h1234;
        wr_req = 1'b1; wr_we = 1'b1; wr_adr = 16'h0005; wr_wdata = 24'h000007;
        reset = 1'b0;
        #1;
        checks++; if (vga_d !== 24'h0) begin errors++; $display("FAIL rst_vga_d got=%h exp=0", vga_d); end
        checks++; if (wr_rdata !== 24'h0) begin errors++; $display("FAIL rst_wr_rdata got=%h exp=0", wr_rdata); end
        checks++; if (wr_ack !== 1'b0) begin errors++; $display("FAIL rst_wr_ack got=%b exp=0", wr_ack); end
        checks++; if (wr_rvalid !== 1'b0) begin errors++; $display("FAIL rst_wr_rvalid got=%b exp=0", wr_rvalid); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we got=%b exp=0", mem_we); end
        checks++; if (mem_adr !== 16'h0) begin errors++; $display("FAIL rst_mem_adr got=%h exp=0", mem_adr); end
        checks++; if (mem_wdata !== 24'h0) begin errors++; $display("FAIL rst_mem_wdata got=%h exp=0", mem_wdata); end
        wr_req = 1'b0;
        @(posedge CLOCK_50);
        @(posedge CLOCK_50);
        #1 reset = 1'b1;
        #1;
        checks++; if (mem_adr !== 16'h1234) begin errors++; $display("FAIL rel_mem_adr got=%h exp=1234", mem_adr); end
        $display("test_reset done");
    endtask

    task automatic test_scanout;
        vga_adr = 16'h0010;
        #1;
        checks++; if (mem_adr !== 16'h0010) begin errors++; $display("FAIL scan_adr got=%h exp=0010", mem_adr); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL scan_we got=%b exp=0", mem_we); end
        tick;
        checks++; if (vga_d !== 24'h0) begin errors++; $display("FAIL scan_early got=%h exp=0", vga_d); end
        tick;
        checks++; if (vga_d !== 24'hAA5500) begin errors++; $display("FAIL scan_pix0 got=%h exp=aa5500", vga_d); end
        vga_adr = 16'h0011;
        tick;
        checks++; if (vga_d !== 24'hAA5500) begin errors++; $display("FAIL scan_hold got=%h exp=aa5500", vga_d); end
        tick;
        checks++; if (vga_d !== 24'h00BEEF) begin errors++; $display("FAIL scan_pix1 got=%h exp=00beef", vga_d); end
        $display("test_scanout pixels aa5500 00beef");
    endtask

    task automatic test_write_read;
        // Starts in a slot-0 cycle with scanout active
        wr_req = 1'b1; wr_we = 1'b1; wr_adr = 16'h0020; wr_wdata = 24'h123456;
        #1;
        checks++; if (wr_ack !== 1'b0) begin errors++; $display("FAIL wr_slot0_ack got=%b exp=0", wr_ack); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL wr_slot0_we got=%b exp=0", mem_we); end
        tick;
        checks++; if (wr_ack !== 1'b1) begin errors++; $display("FAIL wr_ack got=%b exp=1", wr_ack); end
        checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL wr_mem_we got=%b exp=1", mem_we); end
        checks++; if (mem_adr !== 16'h0020) begin errors++; $display("FAIL wr_mem_adr got=%h exp=0020", mem_adr); end
        checks++; if (mem_wdata !== 24'h123456) begin errors++; $display("FAIL wr_mem_wdata got=%h exp=123456", mem_wdata); end
        tick;
        wr_we = 1'b0;
        #1;
        checks++; if (wr_ack !== 1'b0) begin errors++; $display("FAIL rd_slot0_ack got=%b exp=0", wr_ack); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL wr_once got=%b exp=0", mem_we); end
        tick;
        checks++; if (wr_ack !== 1'b1) begin errors++; $display("FAIL rd_ack got=%b exp=1", wr_ack); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rd_mem_we got=%b exp=0", mem_we); end
        checks++; if (mem_adr !== 16'h0020) begin errors++; $display("FAIL rd_mem_adr got=%h exp=0020", mem_adr); end
        tick;
        wr_req = 1'b0;
        checks++; if (wr_rvalid !== 1'b0) begin errors++; $display("FAIL rd_early_rvalid got=%b exp=0", wr_rvalid); end
        tick;
        checks++; if (wr_rvalid !== 1'b1) begin errors++; $display("FAIL rd_rvalid got=%b exp=1", wr_rvalid); end
        checks++; if (wr_rdata !== 24'h123456) begin errors++; $display("FAIL rd_rdata got=%h exp=123456", wr_rdata); end
        tick;
        checks++; if (wr_rvalid !== 1'b0) begin errors++; $display("FAIL rd_rvalid_pulse got=%b exp=0", wr_rvalid); end
        $display("test_write_read adr=0020 data=123456");
    endtask

    task automatic test_vga_disabled;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        vga_en = 1'b0;
        for (int k = 0; k < 6; k++) begin
            a = 16'h0040 + AW'(k);
            d = 24'h0A0000 + DW'(k * 17);
            wr_req = 1'b1; wr_we = 1'b1; wr_adr = a; wr_wdata = d;
            #1;
            checks++; if (wr_ack !== 1'b1) begin errors++; $display("FAIL dis_ack[%0d] got=%b exp=1", k, wr_ack); end
            checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL dis_we[%0d] got=%b exp=1", k, mem_we); end
            checks++; if (mem_adr !== a) begin errors++; $display("FAIL dis_adr[%0d] got=%h exp=%h", k, mem_adr, a); end
            tick;
        end
        wr_req = 1'b0;
        checks++; if (vga_d !== 24'h00BEEF) begin errors++; $display("FAIL dis_vga_hold got=%h exp=00beef", vga_d); end
        for (int k = 0; k < 6; k++) begin
            d = 24'h0A0000 + DW'(k * 17);
            checks++; if (ram[16'h0040 + AW'(k)] !== d) begin errors++; $display("FAIL dis_ram[%0d] got=%h exp=%h", k, ram[16'h0040 + AW'(k)], d); end
        end
        // Read, then a write held through RD_WAIT must wait one cycle
        wr_req = 1'b1; wr_we = 1'b0; wr_adr = 16'h0042;
        #1;
        checks++; if (wr_ack !== 1'b1) begin errors++; $display("FAIL dis_rd_ack got=%b exp=1", wr_ack); end
        tick;
        wr_we = 1'b1; wr_adr = 16'h0050; wr_wdata = 24'hABCDEF;
        #1;
        checks++; if (wr_ack !== 1'b0) begin errors++; $display("FAIL rdwait_ack got=%b exp=0", wr_ack); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rdwait_we got=%b exp=0", mem_we); end
        tick;
        checks++; if (wr_ack !== 1'b1) begin errors++; $display("FAIL after_rdwait_ack got=%b exp=1", wr_ack); end
        checks++; if (wr_rvalid !== 1'b1) begin errors++; $display("FAIL dis_rvalid got=%b exp=1", wr_rvalid); end
        checks++; if (wr_rdata !== 24'h0A0022) begin errors++; $display("FAIL dis_rdata got=%h exp=0a0022", wr_rdata); end
        tick;
        wr_req = 1'b0;
        checks++; if (vga_d !== 24'h00BEEF) begin errors++; $display("FAIL dis_vga_hold2 got=%h exp=00beef", vga_d); end
        $display("test_vga_disabled 6 writes + read/write through RD_WAIT");
    endtask

    task automatic test_reset_mid_read;
        logic got;
        got = 1'b0;
        vga_en = 1'b1; vga_adr = 16'h0010;
        wr_req = 1'b1; wr_we = 1'b0; wr_adr = 16'h0020;
        for (int i = 0; i < 4 && !got; i++) begin
            #1;
            if (wr_ack === 1'b1) got = 1'b1;
            tick;
        end
        checks++; if (got !== 1'b1) begin errors++; $display("FAIL mid_rd_ack_timeout got=%b exp=1", got); end
        wr_req = 1'b0;
        reset = 1'b0;
        #1;
        checks++; if (vga_d !== 24'h0) begin errors++; $display("FAIL mid_vga_d got=%h exp=0", vga_d); end
        checks++; if (wr_rdata !== 24'h0) begin errors++; $display("FAIL mid_wr_rdata got=%h exp=0", wr_rdata); end
        checks++; if (wr_rvalid !== 1'b0) begin errors++; $display("FAIL mid_rvalid got=%b exp=0", wr_rvalid); end
        checks++; if (mem_adr !== 16'h0) begin errors++; $display("FAIL mid_mem_adr got=%h exp=0", mem_adr); end
        @(posedge CLOCK_50);
        @(posedge CLOCK_50);
        #1 reset = 1'b1;
`ifndef FB_ARB_WQUEUE_EN
        wr_req = 1'b1; wr_we = 1'b1; wr_adr = 16'h0060; wr_wdata = 24'h0F0F0F;
`endif
        #1;
        checks++; if (mem_adr !== 16'h0010) begin errors++; $display("FAIL mid_rel_scan got=%h exp=0010", mem_adr); end
`ifndef FB_ARB_WQUEUE_EN
        checks++; if (wr_ack !== 1'b0) begin errors++; $display("FAIL mid_rel_slot0 got=%b exp=0", wr_ack); end
`endif
        for (int i = 0; i < 3; i++) begin
            tick;
`ifndef FB_ARB_WQUEUE_EN
            if (i == 0) begin
                checks++; if (wr_ack !== 1'b1) begin errors++; $display("FAIL mid_rel_slot1 got=%b exp=1", wr_ack); end
                wr_req = 1'b0;
            end
`endif
            checks++; if (wr_rvalid !== 1'b0) begin errors++; $display("FAIL mid_no_rvalid[%0d] got=%b exp=0", i, wr_rvalid); end
        end
        $display("test_reset_mid_read read dropped");
    endtask

`ifdef FB_ARB_WQUEUE_EN
    task automatic test_queue;
        int waited;
        logic got;
        do_reset;
        vga_en = 1'b1; vga_adr = 16'h0010;
        for (int k = 0; k < 5; k++) begin
            wr_req = 1'b1; wr_we = 1'b1; wr_adr = 16'h0070 + AW'(k); wr_wdata = 24'h100000 + DW'(k);
            got = 1'b0; waited = 0;
            for (int i = 0; i < 8 && !got; i++) begin
                #1;
                if (wr_ack === 1'b1) got = 1'b1; else waited++;
                tick;
            end
            checks++; if (got !== 1'b1) begin errors++; $display("FAIL q_ack_timeout[%0d] got=%b exp=1", k, got); end
            if (k < 4) begin
                checks++; if (waited !== 0) begin errors++; $display("FAIL q_ack_immediate[%0d] waited=%0d exp=0", k, waited); end
            end
        end
        wr_req = 1'b0;
        repeat (12) tick;
        for (int k = 0; k < 5; k++) begin
            checks++; if (ram[16'h0070 + AW'(k)] !== 24'h100000 + DW'(k)) begin errors++; $display("FAIL q_ram[%0d] got=%h exp=%h", k, ram[16'h0070 + AW'(k)], 24'h100000 + DW'(k)); end
        end
        $display("test_queue 5 posted writes");
    endtask
`endif

    initial begin
        for (int i = 0; i < 65536; i++) ram[i] = '0;
        ram[16'h0010] = 24'hAA5500;
        ram[16'h0011] = 24'h00BEEF;
        test_reset;
        test_scanout;
`ifdef FB_ARB_WQUEUE_EN
        test_queue;
`else
        test_write_read;
        test_vga_disabled;
`endif
        test_reset_mid_read;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute time limit so the bench always ends on its own
    initial begin
        #100000;
        $display("FAIL timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end
endmodule
